// File: rtl/ltc_bmc_serialiser.sv
// SMPTE 12M LTC frame serialiser: 64-bit payload + sync word, biphase-mark coded onto ltc_out_o.
// Optional `LTC_POLARITY_CORRECT_EN: rewrite payload bit POL_BIT so each frame has an even count of 0 bits.
module ltc_bmc_serialiser #(
   parameter int CLK_FREQ = 25000000,
   parameter int LTC_FPS  = 25,
   parameter int POL_BIT  = 59
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] frame_data_i,
   input  logic        frame_valid_i,
   output logic        frame_ready_o,
   output logic        ltc_out_o,
   output logic        frame_start_o,
   output logic        underrun_o
);

   localparam int HALF_DIV = CLK_FREQ / (LTC_FPS * 160);
   localparam int CW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   // Sync 0x3FFD goes out as 0,0,1x12,0,1 on bits 64..79; this is that order packed LSB-first.
   localparam logic [15:0] SYNC_LSB = 16'hBFFC;

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state_q, state_d;
   logic [63:0]   hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic [79:0]   shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    bit_q, bit_d;
   logic          mid_q, mid_d;
   logic          ltc_q, ltc_d;
   logic          fs_q, fs_d;
   logic          ur_q, ur_d;

   logic          accept;
   logic          tick;
   logic          load;
   logic [63:0]   payload;

   assign frame_ready_o = reset_n & ~hold_full_q;
   assign accept        = frame_valid_i & frame_ready_o;
   assign tick          = (cnt_q == CW'(HALF_DIV - 1));
   assign ltc_out_o     = ltc_q;
   assign frame_start_o = fs_q;
   assign underrun_o    = ur_q;

   always_comb begin
      payload = hold_q;
`ifdef LTC_POLARITY_CORRECT_EN
      // Sync holds three 0s, so forcing the bit to 0 and then setting it when the
      // remaining payload has an even number of 1s leaves the frame's 0 count even.
      payload[POL_BIT] = 1'b0;
      payload[POL_BIT] = ~^payload;
`endif
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      mid_d       = mid_q;
      ltc_d       = ltc_q;
      fs_d        = 1'b0;
      ur_d        = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: load = hold_full_q;
         SEND: begin
            cnt_d = tick ? '0 : CW'(cnt_q + 1'b1);
            if (tick) begin
               if (!mid_q) begin
                  mid_d = 1'b1;
                  if (shift_q[0]) ltc_d = ~ltc_q;
               end else begin
                  mid_d = 1'b0;
                  if (bit_q == 7'd79) begin
                     if (hold_full_q) begin
                        load = 1'b1;
                     end else begin
                        ur_d    = 1'b1;
                        state_d = IDLE;
                     end
                  end else begin
                     bit_d   = bit_q + 7'd1;
                     shift_d = {1'b0, shift_q[79:1]};
                     ltc_d   = ~ltc_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame start: shared by the idle launch and the seamless end-of-frame reload.
      if (load) begin
         shift_d     = {SYNC_LSB, payload};
         hold_full_d = 1'b0;
         ltc_d       = ~ltc_q;
         fs_d        = 1'b1;
         cnt_d       = '0;
         bit_d       = '0;
         mid_d       = 1'b0;
         state_d     = SEND;
      end

      if (accept) begin
         hold_d      = frame_data_i;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         bit_q       <= '0;
         mid_q       <= 1'b0;
         ltc_q       <= 1'b0;
         fs_q        <= 1'b0;
         ur_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         mid_q       <= mid_d;
         ltc_q       <= ltc_d;
         fs_q        <= fs_d;
         ur_q        <= ur_d;
      end
   end

endmodule
